// File: rtl/shift_unit_pipe_if.sv
// Handshake bundle for the pipelined shifter: producer-side operation fields,
// consumer-side result fields and the pipeline-wide flush.
interface shift_unit_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    localparam int SHW = $clog2(XLEN);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_word;
    logic [XLEN-1:0]  in_data;
    logic [SHW-1:0]   in_shamt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_op, in_word, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  flush, in_valid, in_op, in_word, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA plus RV64 word variants) with an
// elastic valid/ready pipeline, flush and asynchronous reset.
module shift_unit_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic           clk,
    input  logic           rst,
    shift_unit_pipe_if.slave bus
);
    localparam int L       = $clog2(XLEN);
    localparam int P       = (L + STAGES - 1) / STAGES;
    localparam bit WORD_OK = (XLEN == 64);

    logic             valid_q [STAGES];
    logic [XLEN-1:0]  data_q  [STAGES];
    logic [L-1:0]     shamt_q [STAGES];
    logic [1:0]       op_q    [STAGES];
    logic             word_q  [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];

    logic             adv        [STAGES];
    logic             nxt_valid  [STAGES];
    logic [XLEN-1:0]  nxt_data   [STAGES];
    logic [L-1:0]     nxt_shamt  [STAGES];
    logic [1:0]       nxt_op     [STAGES];
    logic             nxt_word   [STAGES];
    logic [TAG_W-1:0] nxt_tag    [STAGES];

    // Word-mode right shifts see the fill bit above bit 31, so the normal
    // XLEN-wide shifter produces the correct low word.
    function automatic logic [XLEN-1:0] word_prep(input logic [XLEN-1:0] d,
                                                  input logic [1:0] op);
        logic [XLEN-1:0] r;
        logic            fill;
        r    = d;
        fill = (op == 2'b10) && d[31];
        if (op != 2'b00) begin
            for (int b = 32; b < XLEN; b++) r[b] = fill;
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] stage_shift(input logic [XLEN-1:0] d,
                                                    input logic [L-1:0] sh,
                                                    input logic [1:0] op,
                                                    input logic word,
                                                    input int stage);
        logic [XLEN-1:0] r;
        logic            fill;
        r = d;
        for (int k = 0; k < L; k++) begin
            if (((k / P) == stage) && sh[k]) begin
                fill = (op == 2'b10) && r[XLEN-1];
                if (op == 2'b00)
                    r = r << (1 << k);
                else
                    r = (r >> (1 << k)) | ({XLEN{fill}} & ~({XLEN{1'b1}} >> (1 << k)));
            end
        end
        if ((stage == STAGES - 1) && word) begin
            for (int b = 32; b < XLEN; b++) r[b] = r[31];
        end
        return r;
    endfunction

    // A stage may load when it or any stage downstream of it has a free slot.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            adv[i] = bus.out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!valid_q[j]) adv[i] = 1'b1;
            end
        end
    end

    always_comb begin : stage_logic
        logic             w0;
        logic [L-1:0]     s0;
        w0 = WORD_OK && bus.in_word;
        s0 = bus.in_shamt;
        if (w0) s0[L-1] = 1'b0;
        nxt_valid[0] = bus.in_valid;
        nxt_shamt[0] = s0;
        nxt_op[0]    = bus.in_op;
        nxt_word[0]  = w0;
        nxt_tag[0]   = bus.in_tag;
        nxt_data[0]  = stage_shift(w0 ? word_prep(bus.in_data, bus.in_op) : bus.in_data,
                                   s0, bus.in_op, w0, 0);
        for (int i = 1; i < STAGES; i++) begin
            nxt_valid[i] = valid_q[i-1];
            nxt_shamt[i] = shamt_q[i-1];
            nxt_op[i]    = op_q[i-1];
            nxt_word[i]  = word_q[i-1];
            nxt_tag[i]   = tag_q[i-1];
            nxt_data[i]  = stage_shift(data_q[i-1], shamt_q[i-1], op_q[i-1], word_q[i-1], i);
        end
    end

    // Payload only loads with a valid entry so a stalled output stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                shamt_q[i] <= '0;
                op_q[i]    <= '0;
                word_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (bus.flush)
                    valid_q[i] <= 1'b0;
                else if (adv[i])
                    valid_q[i] <= nxt_valid[i];
                if (adv[i] && nxt_valid[i]) begin
                    data_q[i]  <= nxt_data[i];
                    shamt_q[i] <= nxt_shamt[i];
                    op_q[i]    <= nxt_op[i];
                    word_q[i]  <= nxt_word[i];
                    tag_q[i]   <= nxt_tag[i];
                end
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];
endmodule
